// File: rtl/bk_pkg.sv
// Shared constants and state type for the 12-bit Brent-Kung adder and its
// operand-recovery checker.
package bk_pkg;

    localparam int WIDTH = 12;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int KW    = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bk_digit_sub.sv
// One DIGIT-wide slice of a ripple subtractor: diff = a - b - bin, with the
// borrow out taken from the extra top bit of the widened difference.
module bk_digit_sub #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] diff_o,
    output logic             bout_o
);

    logic [DIGIT:0] full;

    assign full   = {1'b0, a_i} - {1'b0, b_i} - {{DIGIT{1'b0}}, bin_i};
    assign diff_o = full[DIGIT-1:0];
    assign bout_o = full[DIGIT];

endmodule

// File: rtl/bk_sum_recover.sv
// Recovers operand B = S - A from a logged adder sum, DIGIT bits per cycle,
// with valid/ready on both sides and an error flag when no legal B exists.
module bk_sum_recover #(
    parameter int WIDTH = bk_pkg::WIDTH,
    parameter int DIGIT = bk_pkg::DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] a_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_o,
    output logic             err_o
);
    import bk_pkg::*;

    localparam int NUM_DIG = WIDTH / DIGIT;
    localparam int CNT_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NUM_DIG - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("bk_sum_recover: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends combinationally on ready.
    state_e           state_q, state_d;
    logic [WIDTH:0]   s_q, s_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] s_dig, a_dig, diff;
    logic             bout;

    assign s_dig = s_q[k_q*DIGIT +: DIGIT];
    assign a_dig = a_q[k_q*DIGIT +: DIGIT];

    bk_digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
        .a_i    (s_dig),
        .b_i    (a_dig),
        .bin_i  (borrow_q),
        .diff_o (diff),
        .bout_o (bout)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        a_d         = a_q;
        res_d       = res_q;
        borrow_d    = borrow_q;
        k_d         = k_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    s_d        = sum_i;
                    a_d        = a_i;
                    borrow_d   = 1'b0;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                res_d[k_q*DIGIT +: DIGIT] = diff;
                borrow_d = bout;
                if (k_q == K_LAST) begin
                    // Legal only when the carry-out exactly cancels the final borrow.
                    err_d       = bout ^ s_q[WIDTH];
                    k_d         = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            a_q         <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            k_q         <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            a_q         <= a_d;
            res_q       <= res_d;
            borrow_q    <= borrow_d;
            k_q         <= k_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign b_o       = res_q;
    assign err_o     = err_q;

endmodule
